// File: rtl/dcache_mem_arbiter.sv
// Arbitrates two data-cache ports onto one burst memory interface (line fills and write-backs).
// Define DCACHE_ARB_RR_EN for round-robin arbitration of simultaneous requests; otherwise port 1 always wins.
module dcache_mem_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BEATS  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            wnext,
    output logic [1:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            done,
    output logic [1:0]            stall_miss,
    output logic [1:0]            write_dirty,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_wlast,
    input  logic                  mem_wready,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    input  logic                  mem_bvalid,
    output logic                  mem_bready
);

    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned OFF_W = $clog2(BEATS * DATA_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRESP,
        RDATA,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                grant;
    logic [1:0]          own_oh;
`ifdef DCACHE_ARB_RR_EN
    // Most recently granted port; resets to port 2 so port 1 wins first.
    logic                last_q, last_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
`ifdef DCACHE_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
`ifdef DCACHE_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
`ifdef DCACHE_ARB_RR_EN
        last_d  = last_q;
        grant   = (req == 2'b11) ? ~last_q : ~req[0];
`else
        grant   = ~req[0];
`endif
        own_oh      = owner_q ? 2'b10 : 2'b01;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wlast   = 1'b0;
        mem_bready  = 1'b0;
        wnext       = '0;
        rvalid      = '0;
        rdata       = '0;
        done        = '0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = grant;
                    we_d    = we[grant];
                    addr_d  = (grant ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0]) & LINE_MASK;
                    state_d = ADDR;
`ifdef DCACHE_ARB_RR_EN
                    last_d  = grant;
`endif
                end
            end
            ADDR: begin
                mem_req  = 1'b1;
                mem_we   = we_q;
                mem_addr = addr_q;
                if (mem_ack) begin
                    cnt_d   = '0;
                    state_d = we_q ? WDATA : RDATA;
                end
            end
            WDATA: begin
                mem_wdata = owner_q ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
                mem_wlast = (cnt_q == LAST_BEAT);
                if (mem_wready) begin
                    wnext = own_oh;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = WRESP;
                end
            end
            WRESP: begin
                mem_bready = 1'b1;
                if (mem_bvalid) state_d = DONE;
            end
            RDATA: begin
                rdata  = mem_rdata;
                rvalid = mem_rvalid ? own_oh : 2'b00;
                if (mem_rvalid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            DONE: begin
                done    = own_oh;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        stall_miss  = req & ~we & ~done;
        write_dirty = req & we & ~done;
    end

endmodule

// File: doc/dcache_mem_arbiter.md
DCACHE_MEM_ARBITER -- requirements
Module: dcache_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 64, byte-address width.
REQ-002 Parameter DATA_W, 64, memory beat width in bits.
REQ-003 Parameter BEATS, 8, beats per cache line; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 req  in  2  per-port line request; bit 0 is data cache port 1, bit 1 is data cache port 2.
REQ-007 we  in  2  per-port direction; 1 means write-back of a dirty line, 0 means miss fill.
REQ-008 addr  in  2*ADDR_W  per-port line address; port 2 occupies the upper half.
REQ-009 wdata  in  2*DATA_W  per-port write-back beat.
REQ-010 wnext  out  2  per-port pulse: current wdata beat consumed.
REQ-011 rvalid  out  2  per-port pulse: rdata holds a valid fill beat.
REQ-012 rdata  out  DATA_W  shared fill data.
REQ-013 done  out  2  per-port one-cycle completion pulse.
REQ-014 stall_miss  out  2  per-port fill pending, routed to the hazard unit.
REQ-015 write_dirty  out  2  per-port write-back pending, routed to the hazard unit.
REQ-016 mem_req, mem_we, mem_addr  out  1/1/ADDR_W  downstream address phase.
REQ-017 mem_ack  in  1  downstream address accepted.
REQ-018 mem_wdata, mem_wlast  out  DATA_W/1  downstream write beat; mem_wready  in  1.
REQ-019 mem_rdata, mem_rvalid  in  DATA_W/1  downstream read beat.
REQ-020 mem_bvalid  in  1  write response; mem_bready  out  1.

Function
REQ-021 FSM states SHALL be IDLE, ADDR, WDATA, WRESP, RDATA and DONE.
REQ-022 IDLE with any req bit high SHALL latch the owner, we, and addr aligned down to BEATS*DATA_W/8 bytes, then move to ADDR; mem_req rises exactly one cycle after req is sampled.
REQ-023 ADDR SHALL drive mem_req=1 with the latched mem_we and mem_addr; mem_ack SHALL move the FSM to WDATA if we=1, otherwise to RDATA, and clear the beat counter.
REQ-024 WDATA SHALL drive mem_wdata from the owner's wdata; on each mem_wready it SHALL pulse wnext[owner] and increment the counter; mem_wlast SHALL be high when counter equals BEATS-1; a wready on the last beat SHALL move the FSM to WRESP.
REQ-025 WRESP SHALL hold mem_bready=1; mem_bvalid SHALL move the FSM to DONE.
REQ-026 RDATA SHALL pass mem_rdata to rdata combinationally and set rvalid[owner]=mem_rvalid; the BEATS-th mem_rvalid SHALL move the FSM to DONE.
REQ-027 DONE SHALL pulse done[owner] for one cycle and then move to IDLE; no grant SHALL occur in DONE.
REQ-028 The beat counter SHALL be clog2(BEATS) bits wide and wrap to 0 after the last beat.
REQ-029 stall_miss[i] SHALL equal req[i] & ~we[i] & ~done[i], and write_dirty[i] SHALL equal req[i] & we[i] & ~done[i].
REQ-030 Requesters SHALL hold req, we and addr until done; once latched, changes to we or addr SHALL be ignored until DONE.
REQ-031 Outputs of the non-owner port (wnext, rvalid, done) SHALL stay 0.

Reset
REQ-032 With reset_n=0 at an edge, the FSM SHALL go to IDLE, the counter SHALL clear, priority SHALL go to port 1, and every registered output SHALL read 0; this includes reset during a transaction, which SHALL be abandoned without a done pulse.

Configuration
REQ-033 Macro DCACHE_ARB_RR_EN: when defined, simultaneous requests SHALL be granted round-robin, with the port not most recently granted winning; when undefined, port 1 SHALL always win.

Verification
REQ-034 Port 1 fill at 0x1038, BEATS=8 -> mem_addr=0x1000; 8 rvalid[0] pulses carry mem_rdata; done[0] fires the cycle after the 8th beat.
REQ-035 Port 2 write-back with mem_wready low on alternate cycles -> 8 wnext[1] pulses; mem_wlast only on beat 7; done[1] fires after mem_bvalid.
REQ-036 Both ports request in the same cycle, three times back to back -> with RR_EN grants go 0,1,0; without it grants go 0,0,0 while port 2 stays stalled.
REQ-037 reset_n driven low during beat 4 of a fill -> next cycle is IDLE, all outputs are 0, and no done pulse occurs.
REQ-038 req held high through DONE -> no regrant in the DONE cycle; a regrant occurs in IDLE only if req is still high.
